// File: rtl/train_balancer_pkg.sv
// Shared constants, load-sequencer state type and saturating helpers for the
// train balancer stations.
package train_balancer_pkg;

    localparam int DEF_QUEUE_LENGTH        = 3;
    localparam int DEF_MAX_STOREABLE       = 128000;
    localparam int DEF_UNITS_IN_TRAIN_LOAD = 8000;
    localparam int DEF_INT                 = 31;

    typedef enum logic [1:0] {
        IDLE,
        LOADING,
        DEPART
    } load_state_t;

    function automatic logic [DEF_INT:0] sat_sub(input logic [DEF_INT:0] a,
                                                 input logic [DEF_INT:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/pickup_train_station_if.sv
// Station bus: network/stock/platform inputs and the published limit and
// loader controls.
interface pickup_train_station_if #(
    parameter int INT = 31
);
    logic [INT:0] precision;
    logic [INT:0] number_of_stations;
    logic [INT:0] total_percentage_available;
    logic [INT:0] units_at_this_station;
    logic [INT:0] train_count;
    logic [INT:0] stopped_train_id;
    logic [INT:0] units_loaded;
    logic [INT:0] percentage_available;
    logic [INT:0] trains_limit;
    logic         load_enable;
    logic         depart;
    logic [INT:0] cargo_in_train;

    modport master (
        output precision, number_of_stations, total_percentage_available,
               units_at_this_station, train_count, stopped_train_id, units_loaded,
        input  percentage_available, trains_limit, load_enable, depart, cargo_in_train
    );

    modport slave (
        input  precision, number_of_stations, total_percentage_available,
               units_at_this_station, train_count, stopped_train_id, units_loaded,
        output percentage_available, trains_limit, load_enable, depart, cargo_in_train
    );

endinterface

// File: rtl/pickup_limit_calc.sv
// Combinational uncommitted-stock percentage and train-limit computation;
// the parent registers both results.
module pickup_limit_calc
    import train_balancer_pkg::*;
#(
    parameter int QUEUE_LENGTH        = DEF_QUEUE_LENGTH,
    parameter int MAX_STOREABLE       = DEF_MAX_STOREABLE,
    parameter int UNITS_IN_TRAIN_LOAD = DEF_UNITS_IN_TRAIN_LOAD,
    parameter int INT                 = DEF_INT
) (
    input  logic [INT:0] precision,
    input  logic [INT:0] number_of_stations,
    input  logic [INT:0] total_percentage_available,
    input  logic [INT:0] units_at_this_station,
    input  logic [INT:0] train_count,
    input  logic [INT:0] stopped_train_id,
    output logic [INT:0] percentage_available,
    output logic [INT:0] trains_limit
);

    localparam logic [63:0] W64 = 64'(UNITS_IN_TRAIN_LOAD);
    localparam logic [63:0] M64 = 64'(MAX_STOREABLE);
    localparam logic [63:0] Q64 = 64'(QUEUE_LENGTH);

    logic [63:0] en_route, committed, available, pct, avg;
    logic [63:0] trains_for_stock, surplus, limit;

    // 64-bit intermediates keep the products exact before dividing back down.
    always_comb begin
        en_route  = 64'(sat_sub(train_count,
                                (stopped_train_id != '0) ? (INT+1)'(1) : '0));
        committed = en_route * W64;
        available = (64'(units_at_this_station) > committed)
                  ? 64'(units_at_this_station) - committed : '0;
        pct       = (available * 64'(precision)) / M64;
        avg       = 64'(total_percentage_available /
                        ((number_of_stations == '0) ? (INT+1)'(1) : number_of_stations));
        trains_for_stock = available / W64;
        surplus = (precision == '0) ? '0
                : ((((pct > avg) ? pct - avg : '0) * M64) / 64'(precision)) / W64;
        if (surplus == '0) surplus = 64'd1;
        limit = trains_for_stock;
        if (surplus < limit) limit = surplus;
        if (Q64 < limit)     limit = Q64;
        if ((pct < avg) || (available < W64)) limit = '0;
    end

    assign percentage_available = pct[INT:0];
    assign trains_limit         = limit[INT:0];

endmodule

// File: rtl/pickup_train_station.sv
// Pickup station: registered stock/limit publication plus the platform load
// sequencer. Optional stall timeout enabled by PICKUP_LOAD_TIMEOUT_EN.
module pickup_train_station
    import train_balancer_pkg::*;
#(
    parameter int QUEUE_LENGTH        = DEF_QUEUE_LENGTH,
    parameter int MAX_STOREABLE       = DEF_MAX_STOREABLE,
    parameter int UNITS_IN_TRAIN_LOAD = DEF_UNITS_IN_TRAIN_LOAD,
    parameter int INT                 = DEF_INT
`ifdef PICKUP_LOAD_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES    = 600
`endif
) (
    input logic                   clk,
    input logic                   rst,
    pickup_train_station_if.slave bus
);

    localparam logic [INT:0] W = (INT+1)'(UNITS_IN_TRAIN_LOAD);

    logic [INT:0] pct_calc, limit_calc;
    logic [INT:0] pct_p0, limit_p0;
    load_state_t  state;
    logic [INT:0] cur_id, cargo;
    logic         load_en, depart_p0;
    logic [INT:0] cargo_sum, entry_cargo;
    logic         timeout_hit;

    function automatic logic [INT:0] sat_add_cap(input logic [INT:0] a,
                                                 input logic [INT:0] b);
        logic [INT+1:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= {1'b0, W}) ? W : s[INT:0];
    endfunction

    pickup_limit_calc #(
        .QUEUE_LENGTH        (QUEUE_LENGTH),
        .MAX_STOREABLE       (MAX_STOREABLE),
        .UNITS_IN_TRAIN_LOAD (UNITS_IN_TRAIN_LOAD),
        .INT                 (INT)
    ) u_calc (
        .precision                  (bus.precision),
        .number_of_stations         (bus.number_of_stations),
        .total_percentage_available (bus.total_percentage_available),
        .units_at_this_station      (bus.units_at_this_station),
        .train_count                (bus.train_count),
        .stopped_train_id           (bus.stopped_train_id),
        .percentage_available       (pct_calc),
        .trains_limit               (limit_calc)
    );

    assign cargo_sum   = sat_add_cap(cargo, bus.units_loaded);
    assign entry_cargo = sat_add_cap('0, bus.units_loaded);

`ifdef PICKUP_LOAD_TIMEOUT_EN
    logic [31:0] stall, stall_next;
    // Counter saturates at the window so an empty train can wait indefinitely.
    assign stall_next  = (bus.units_loaded != '0) ? '0
                       : (stall >= 32'(TIMEOUT_CYCLES)) ? stall : stall + 32'd1;
    assign timeout_hit = (stall_next >= 32'(TIMEOUT_CYCLES)) && (cargo_sum != '0);

    always_ff @(posedge clk) begin
        if (rst || state != LOADING || bus.stopped_train_id != cur_id) stall <= '0;
        else                                                          stall <= stall_next;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Stage p0: registered publication and sequencer outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_id    <= '0;
            cargo     <= '0;
            load_en   <= 1'b0;
            depart_p0 <= 1'b0;
            pct_p0    <= '0;
            limit_p0  <= '0;
        end else begin
            pct_p0    <= pct_calc;
            limit_p0  <= limit_calc;
            depart_p0 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.stopped_train_id != '0) begin
                        cur_id <= bus.stopped_train_id;
                        cargo  <= entry_cargo;
                        if (entry_cargo == W) begin
                            state     <= DEPART;
                            depart_p0 <= 1'b1;
                            load_en   <= 1'b0;
                        end else begin
                            state   <= LOADING;
                            load_en <= 1'b1;
                        end
                    end
                end
                LOADING: begin
                    if (bus.stopped_train_id == '0) begin
                        state   <= IDLE;
                        cargo   <= '0;
                        load_en <= 1'b0;
                    end else if (bus.stopped_train_id != cur_id) begin
                        cur_id <= bus.stopped_train_id;
                        cargo  <= '0;
                    end else begin
                        cargo <= cargo_sum;
                        if ((cargo_sum == W) || timeout_hit) begin
                            state     <= DEPART;
                            depart_p0 <= 1'b1;
                            load_en   <= 1'b0;
                        end
                    end
                end
                DEPART: begin
                    if (bus.stopped_train_id == '0) begin
                        state <= IDLE;
                        cargo <= '0;
                    end else if (bus.stopped_train_id != cur_id) begin
                        state   <= LOADING;
                        cur_id  <= bus.stopped_train_id;
                        cargo   <= '0;
                        load_en <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.percentage_available = pct_p0;
    assign bus.trains_limit         = limit_p0;
    assign bus.load_enable          = load_en;
    assign bus.depart               = depart_p0;
    assign bus.cargo_in_train       = cargo;

endmodule

// File: doc/pickup_train_station.md
Name: pickup_train_station

Overview:
- Supply-side counterpart of the dropoff station, sitting at a provider stop.
- Computes how much local stock is not yet promised to trains already en route. Publishes this as a percentage for network-wide averaging and sets its own train limit from it.
- Runs a load sequencer for the train at the platform: enables inserters, counts loaded units, issues a single-cycle depart command.
- All outputs are registered.

Parameters:
- QUEUE_LENGTH, 3: maximum train limit ever published.
- MAX_STOREABLE, 128000: station buffer capacity in units.
- UNITS_IN_TRAIN_LOAD, 8000: units in one full train.
- TIMEOUT_CYCLES, 600: stall window used only when PICKUP_LOAD_TIMEOUT_EN is defined.
- INT, 31: MSB index of every data bus.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- precision  in  INT+1  percentage scale P
- number_of_stations  in  INT+1  pickup stations in the network, G
- total_percentage_available  in  INT+1  network sum of percentage_available
- units_at_this_station  in  INT+1  stock in the station buffer, U
- train_count  in  INT+1  trains assigned to this stop, including a stopped one, C
- stopped_train_id  in  INT+1  id of the train at the platform, 0 = none
- units_loaded  in  INT+1  units moved into the train this cycle
- percentage_available  out  INT+1  uncommitted stock scaled by P
- trains_limit  out  INT+1  train limit L
- load_enable  out  1  inserters on
- depart  out  1  one-cycle depart command
- cargo_in_train  out  INT+1  units loaded into the current train

Behaviour:
- Reset: every output is 0 and the FSM is IDLE. Reset mid-load abandons the load without a depart pulse.

Committed stock (computed combinationally, then registered):
- en_route = C − (T≠0 ? 1 : 0), saturating at 0.
- committed = en_route × W.
- available = U > committed ? U − committed : 0.
- percentage_available = available × P / M.
- Latency is exactly one cycle from an input change to percentage_available and trains_limit.

Train limit:
- avg = R / max(G,1).
- trains_for_stock = available / W.
- surplus_trains = ((percentage_available − avg) × M / P) / W, clipped to a minimum of 1.
- L = min(trains_for_stock, surplus_trains, QUEUE_LENGTH).
- Forced to 0 when percentage_available < avg or when available < W.
- All subtractions saturate at 0. Division by a P of 0 yields 0.

FSM states:
- IDLE:
  - load_enable = 0, cargo_in_train = 0.
  - When T≠0, latch T into cur_id and go to LOADING next cycle.
- LOADING:
  - load_enable = 1.
  - cargo += units_loaded, saturating at W.
  - When cargo reaches W, go to DEPART.
  - If T becomes 0, go to IDLE and clear cargo; no depart pulse.
  - If T changes to a different nonzero id, relatch cur_id, clear cargo to 0, and stay in LOADING.
- DEPART:
  - load_enable = 0.
  - depart = 1 on the first DEPART cycle only.
  - Stay until T = 0, then go to IDLE.
  - A new nonzero id while in DEPART goes directly to LOADING with cargo 0.

Simultaneous events:
- units_loaded in the same cycle T drops to 0 is discarded.
- If units_loaded in the cycle entering LOADING is nonzero, it is counted.

Optional Feature:
- Macro: PICKUP_LOAD_TIMEOUT_EN.
- Defined:
  - A stall counter runs in LOADING. It resets on any nonzero units_loaded.
  - When it reaches TIMEOUT_CYCLES with cargo > 0, go to DEPART with a partial load.
  - With cargo = 0, keep waiting.
- Undefined: no counter exists, and LOADING exits only on full cargo or train leaving.

Decomposition:
- Shared package train_balancer_pkg:
  - default constants for QUEUE_LENGTH, MAX_STOREABLE, UNITS_IN_TRAIN_LOAD and INT.
  - load-state enum {IDLE, LOADING, DEPART}.
  - A saturating-subtract function.
- Sub-module pickup_limit_calc: pure combinational committed-stock, percentage and limit logic. Registered in the parent.
- The FSM lives in the parent.

Test Plan:
1. Limit computation: U=40000, C=2, T=0, P=1000, G=2, R=300 → next cycle available=24000, percentage_available=187, avg=150, L=min(3, 1, 3)=1.
2. Below average: U=16000, C=1, T=0, R=1000, G=4 → percentage_available=62 < avg 250 → L=0. Also U=7999, C=0 → L=0 since available < W.
3. Full load: T=5, units_loaded=1000 for 8 cycles → load_enable high from cycle 1. cargo reaches 8000, depart pulses exactly one cycle, load_enable drops. T→0 returns to IDLE.
4. Early leave and swap: T leaves at cargo 3000 → IDLE, cargo 0, no depart. T switches 5→9 mid-load → cargo restarts at 0.
5. Reset: rst asserted at cargo 4000 → all outputs 0 next cycle, no depart.
6. Timeout (macro defined): TIMEOUT_CYCLES=4, cargo 2000, units_loaded=0 for 4 cycles → depart pulses. Macro undefined → stays in LOADING indefinitely.
